muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative RV32M multiply/divide sequencer next to the single-cycle ALU; executes the ALU's unused MULT slot.
//  Takes one operation under a start/busy/done handshake, runs a radix-2 shift-add multiply or restoring divide.
//  Returns one registered result. The core stalls while MD_Busy is high.
// PARAMETERS
//  DWIDTH   32   operand/result width (even, >=8); iteration counter width = $clog2(DWIDTH)+1
// PORTS
//  Clk        in   1       single clock, all state on rising edge
//  Rst_N      in   1       asynchronous, active-low reset
//  MD_Start   in   1       request; accepted only when MD_Busy==0
//  MD_Op      in   3       funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  MD_In_A    in   DWIDTH  rs1 operand, sampled at accept
//  MD_In_B    in   DWIDTH  rs2 operand, sampled at accept
//  MD_Flush   in   1       abort current op (pipeline flush/trap)
//  MD_Busy    out  1       high in CALC and DONE
//  MD_Done    out  1       one-cycle pulse, MD_Out valid this cycle
//  MD_Out     out  DWIDTH  result; holds until next Done
// BEHAVIOUR
//  Reset: async on Rst_N low -> state IDLE, MD_Busy=0, MD_Done=0, MD_Out=0, counter/accumulators=0.
//  States: IDLE, CALC, DONE.
//  IDLE: MD_Start=1 and MD_Flush=0 -> latch op and operand magnitudes, counter=DWIDTH.
//   Operands are sign-taken per op: MULH=both signed, MULHSU=A signed, DIV/REM=both signed, else unsigned.
//   Next state: DONE (fast path) or CALC.
//  Fast paths (IDLE->DONE, Done 1 cycle after accept):
//   - divide by zero: DIV/DIVU -> all ones; REM/REMU -> MD_In_A
//   - signed overflow (A=100..0, B=all ones): DIV -> A; REM -> 0
//  CALC: one iteration per cycle, counter decrements; at counter==1 -> DONE.
//   Multiply: 2*DWIDTH-bit product of magnitudes.
//   Divide: DWIDTH-bit quotient/remainder of magnitudes.
//  DONE entry (register write): apply sign fix-up, then load MD_Out.
//   - product negated if operand signs differ (signed ops)
//   - quotient negated if signs differ
//   - remainder takes dividend sign
//   MUL->low half; MULH/MULHSU/MULHU->high half.
//  DONE: MD_Done=1 for exactly one cycle -> IDLE. MD_Start in DONE is ignored.
//  Latency: normal op accepted in cycle T -> MD_Done in cycle T+DWIDTH+1 (T+33 for DWIDTH=32); fast path T+1.
//  MD_Busy rises cycle T+1, falls with return to IDLE. Back-to-back: next Start accepted cycle after Done.
//  MD_Start while MD_Busy=1: ignored, no queuing.
//  MD_Flush: any state -> IDLE next cycle, no Done, MD_Out unchanged.
//   Flush in DONE cycle: Done still pulses (result already committed).
//   Flush with Start in IDLE: Start dropped.
//  Reset mid-operation: immediate abort, outputs to reset values; no Done.
//  Operands/op are sampled only at accept; input changes during CALC have no effect.
// TESTING
//  MUL A=7,B=0xFFFFFFFD (-3), Start@T -> Done@T+33, MD_Out=0xFFFFFFEB, Busy T+1..T+33
//  MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU A=-1,B=2 -> 0xFFFFFFFF
//  DIV A=0xFFFFFFF9 (-7),B=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2
//  DIVU 5/0 -> Done@T+1, 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM -> 0
//  MUL 3*4 then Flush@T+10 -> no Done, Busy low T+11; Start MUL 5*6 @T+11 -> Done@T+44, MD_Out=30
//  Start held high through Done -> exactly one op per accept; Rst_N low @T+5 -> Busy=0, MD_Out=0 same cycle

Source files
------------

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
//   Iterative RV32M multiply/divide sequencer that sits beside the
//   single-cycle ALU. One operation is accepted under a start/busy/done
//   handshake and executed as a radix-2 shift-add multiply or a restoring
//   divide, one bit per clock. The signed result is corrected once, on the
//   cycle the final iteration completes, and held in a register.
//
// Ports
//   Clk        in   1       clock, all state on the rising edge
//   Rst_N      in   1       asynchronous active-low reset
//   MD_Start   in   1       request, accepted only while idle
//   MD_Op      in   3       funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   MD_In_A    in   DWIDTH  rs1 operand, sampled at accept
//   MD_In_B    in   DWIDTH  rs2 operand, sampled at accept
//   MD_Flush   in   1       abort the operation in flight
//   MD_Busy    out  1       high while an operation is in CALC or DONE
//   MD_Done    out  1       one-cycle pulse, MD_Out valid this cycle
//   MD_Out     out  DWIDTH  result, held until the next Done
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int DWIDTH = 32
) (
    input  logic              Clk,
    input  logic              Rst_N,
    input  logic              MD_Start,
    input  logic [2:0]        MD_Op,
    input  logic [DWIDTH-1:0] MD_In_A,
    input  logic [DWIDTH-1:0] MD_In_B,
    input  logic              MD_Flush,
    output logic              MD_Busy,
    output logic              MD_Done,
    output logic [DWIDTH-1:0] MD_Out
);

    localparam int CW = $clog2(DWIDTH) + 1;
    localparam logic [DWIDTH-1:0] MIN_VAL  = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] ONES_VAL = {DWIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_next;

    logic [2:0]          op_q;
    logic                neg_a_q;
    logic                neg_b_q;
    logic [CW-1:0]       cnt;
    logic [DWIDTH-1:0]   acc_hi;
    logic [DWIDTH-1:0]   acc_lo;
    logic [DWIDTH-1:0]   opnd;

    logic                accept;
    logic                a_signed;
    logic                b_signed;
    logic                a_neg;
    logic                b_neg;
    logic [DWIDTH-1:0]   a_mag;
    logic [DWIDTH-1:0]   b_mag;
    logic                div_zero;
    logic                overflow;
    logic                fast;
    logic [DWIDTH-1:0]   fast_result;

    logic [DWIDTH:0]     mul_sum;
    logic [DWIDTH:0]     div_shift;
    logic [DWIDTH:0]     div_diff;
    logic                div_ge;
    logic [DWIDTH-1:0]   it_hi;
    logic [DWIDTH-1:0]   it_lo;

    logic [2*DWIDTH-1:0] product;
    logic [2*DWIDTH-1:0] product_fix;
    logic [DWIDTH-1:0]   quot_fix;
    logic [DWIDTH-1:0]   rem_fix;
    logic [DWIDTH-1:0]   final_result;

    // Accept decode: operand signedness follows funct3, and the magnitudes
    // are what the unsigned iteration engine works on. Divide by zero and
    // the single signed-overflow case bypass the iterations entirely.
    always_comb begin
        accept      = (state == IDLE) && MD_Start && !MD_Flush;
        a_signed    = (MD_Op == 3'd1) || (MD_Op == 3'd2) ||
                      (MD_Op == 3'd4) || (MD_Op == 3'd6);
        b_signed    = (MD_Op == 3'd1) || (MD_Op == 3'd4) || (MD_Op == 3'd6);
        a_neg       = a_signed && MD_In_A[DWIDTH-1];
        b_neg       = b_signed && MD_In_B[DWIDTH-1];
        a_mag       = a_neg ? (~MD_In_A + 1'b1) : MD_In_A;
        b_mag       = b_neg ? (~MD_In_B + 1'b1) : MD_In_B;
        div_zero    = MD_Op[2] && (MD_In_B == '0);
        overflow    = ((MD_Op == 3'd4) || (MD_Op == 3'd6)) &&
                      (MD_In_A == MIN_VAL) && (MD_In_B == ONES_VAL);
        fast        = div_zero || overflow;
        fast_result = '0;
        if (div_zero) begin
            fast_result = MD_Op[1] ? MD_In_A : ONES_VAL;
        end else if (overflow) begin
            fast_result = MD_Op[1] ? '0 : MD_In_A;
        end
    end

    // One iteration of either engine. The multiply keeps the multiplier in
    // acc_lo and shifts the growing product in from the top; the divide
    // shifts the dividend out of acc_lo into the partial remainder acc_hi
    // and shifts quotient bits in at the bottom.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[DWIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
        if (op_q[2]) begin
            it_hi = div_ge ? div_diff[DWIDTH-1:0] : div_shift[DWIDTH-1:0];
            it_lo = {acc_lo[DWIDTH-2:0], div_ge};
        end else begin
            it_hi = mul_sum[DWIDTH:1];
            it_lo = {mul_sum[0], acc_lo[DWIDTH-1:1]};
        end
    end

    // Sign fix-up applied to the post-iteration values so the result is
    // ready in the same cycle the last bit is produced.
    always_comb begin
        product      = {it_hi, it_lo};
        product_fix  = (neg_a_q ^ neg_b_q) ? (~product + 1'b1) : product;
        quot_fix     = (neg_a_q ^ neg_b_q) ? (~it_lo + 1'b1) : it_lo;
        rem_fix      = neg_a_q ? (~it_hi + 1'b1) : it_hi;
        final_result = '0;
        case (op_q)
            3'd0:    final_result = product_fix[DWIDTH-1:0];
            3'd1,
            3'd2,
            3'd3:    final_result = product_fix[2*DWIDTH-1:DWIDTH];
            3'd4,
            3'd5:    final_result = quot_fix;
            default: final_result = rem_fix;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Flush only matters in CALC; DONE always returns to
    // IDLE because the result has already been committed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = fast ? DONE : CALC;
                end
            end
            CALC: begin
                if (MD_Flush) begin
                    state_next = IDLE;
                end else if (cnt == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        MD_Busy = 1'b0;
        MD_Done = 1'b0;
        case (state)
            CALC: MD_Busy = 1'b1;
            DONE: begin
                MD_Busy = 1'b1;
                MD_Done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath. Multiply is commutative, so A always goes to acc_lo and B
    // to opnd; for divide that is exactly dividend and divisor. MD_Out is
    // written only on entry to DONE, so a flush leaves it untouched.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            MD_Out  <= '0;
        end else if (accept) begin
            op_q    <= MD_Op;
            neg_a_q <= a_neg;
            neg_b_q <= b_neg;
            cnt     <= CW'(DWIDTH);
            acc_hi  <= '0;
            acc_lo  <= a_mag;
            opnd    <= b_mag;
            if (fast) begin
                MD_Out <= fast_result;
            end
        end else if ((state == CALC) && !MD_Flush) begin
            acc_hi <= it_hi;
            acc_lo <= it_lo;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                MD_Out <= final_result;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq
//   Directed, table-driven bench for muldiv_seq with DWIDTH=32. Each table
//   entry is one operation with its hand-computed result and latency
//   (cycles from accept to Done). Multi-cycle corner cases (flush, held
//   start, reset mid-operation, start+flush in idle) are hand sequences.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

    logic        Clk;
    logic        Rst_N;
    logic        MD_Start;
    logic [2:0]  MD_Op;
    logic [31:0] MD_In_A;
    logic [31:0] MD_In_B;
    logic        MD_Flush;
    logic        MD_Busy;
    logic        MD_Done;
    logic [31:0] MD_Out;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    muldiv_seq #(.DWIDTH(32)) dut (
        .Clk      (Clk),
        .Rst_N    (Rst_N),
        .MD_Start (MD_Start),
        .MD_Op    (MD_Op),
        .MD_In_A  (MD_In_A),
        .MD_In_B  (MD_In_B),
        .MD_Flush (MD_Flush),
        .MD_Busy  (MD_Busy),
        .MD_Done  (MD_Done),
        .MD_Out   (MD_Out)
    );

    // Free-running 10 ns clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single comparison: counts it and reports a miss.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called at the falling edge of cycle T+1. Waits, with a cycle budget,
    // for Done; returns the latency in cycles after accept (0 on timeout)
    // and whether Busy stayed high up to and including Done.
    task automatic waitDone(output int lat, output logic [31:0] res,
                            output logic busyOk);
        lat    = 0;
        res    = '0;
        busyOk = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (!MD_Busy) busyOk = 1'b0;
            if (MD_Done) begin
                lat = k;
                res = MD_Out;
                break;
            end
            @(negedge Clk);
        end
    endtask

    // Issues one operation for a single cycle, then scrambles the operand
    // inputs so any sampling after accept would corrupt the result.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output int lat,
                                 output logic [31:0] res, output logic busyOk);
        @(negedge Clk);
        MD_Op    = op;
        MD_In_A  = a;
        MD_In_B  = b;
        MD_Start = 1'b1;
        @(negedge Clk);
        MD_Start = 1'b0;
        MD_Op    = ~op;
        MD_In_A  = ~a;
        MD_In_B  = b ^ 32'h5A5A_A5A5;
        waitDone(lat, res, busyOk);
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        busyOk;
        int          doneSeen;
        logic [31:0] lastOut;

        vecs.push_back('{"MUL 7*-3",        3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vecs.push_back('{"MULHU -1*-1",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{"MULH -1*-1",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33});
        vecs.push_back('{"MULHSU -1*2",     3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33});
        vecs.push_back('{"MULH min*min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
        vecs.push_back('{"MULHSU min*umax", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});
        vecs.push_back('{"MUL lowhalf",     3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33});
        vecs.push_back('{"DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
        vecs.push_back('{"REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
        vecs.push_back('{"DIV -100/7",      3'd4, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 33});
        vecs.push_back('{"REM -100/7",      3'd6, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 33});
        vecs.push_back('{"DIVU 100/7",      3'd5, 32'd100,       32'd7,         32'd14,        33});
        vecs.push_back('{"REMU 100/7",      3'd7, 32'd100,       32'd7,         32'd2,         33});
        vecs.push_back('{"DIVU min/umax",   3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33});
        vecs.push_back('{"DIVU 5/0",        3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{"REM 5/0",         3'd6, 32'd5,         32'd0,         32'd5,         1});
        vecs.push_back('{"REMU 7/0",        3'd7, 32'd7,         32'd0,         32'd7,         1});
        vecs.push_back('{"DIV ovf",         3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{"REM ovf",         3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});

        Rst_N    = 1'b0;
        MD_Start = 1'b0;
        MD_Op    = '0;
        MD_In_A  = '0;
        MD_In_B  = '0;
        MD_Flush = 1'b0;

        repeat (2) @(negedge Clk);
        checkOutput("reset busy", {31'd0, MD_Busy}, 32'd0);
        checkOutput("reset done", {31'd0, MD_Done}, 32'd0);
        checkOutput("reset out",  MD_Out,           32'd0);
        Rst_N = 1'b1;

        // Table-driven operations.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, busyOk);
            checkOutput({vecs[i].name, " result"},  res,        vecs[i].exp);
            checkOutput({vecs[i].name, " latency"}, 32'(lat),   32'(vecs[i].lat));
            checkOutput({vecs[i].name, " busy"},    {31'd0, busyOk}, 32'd1);
            @(negedge Clk);
            checkOutput({vecs[i].name, " idle after"}, {30'd0, MD_Busy, MD_Done}, 32'd0);
        end
        lastOut = vecs[vecs.size()-1].exp;

        // Flush during CALC: MUL 3*4 accepted at T, flush sampled at T+10.
        @(negedge Clk);
        MD_Op = 3'd0; MD_In_A = 32'd3; MD_In_B = 32'd4; MD_Start = 1'b1;
        @(negedge Clk);
        MD_Start = 1'b0;
        doneSeen = 0;
        for (int k = 1; k < 10; k++) begin
            if (MD_Done) doneSeen++;
            @(negedge Clk);
        end
        MD_Flush = 1'b1;
        if (MD_Done) doneSeen++;
        @(negedge Clk);
        MD_Flush = 1'b0;
        checkOutput("flush busy T+11", {31'd0, MD_Busy}, 32'd0);
        checkOutput("flush no done",   32'(doneSeen + int'(MD_Done)), 32'd0);
        checkOutput("flush out held",  MD_Out, lastOut);
        MD_Op = 3'd0; MD_In_A = 32'd5; MD_In_B = 32'd6; MD_Start = 1'b1;
        @(negedge Clk);
        MD_Start = 1'b0;
        waitDone(lat, res, busyOk);
        checkOutput("post-flush MUL result",  res,      32'd30);
        checkOutput("post-flush MUL latency", 32'(lat), 32'd33);

        // Start held high through Done: second op accepted the cycle after.
        @(negedge Clk);
        MD_Op = 3'd0; MD_In_A = 32'd2; MD_In_B = 32'd3; MD_Start = 1'b1;
        @(negedge Clk);
        waitDone(lat, res, busyOk);
        checkOutput("held start 1st latency", 32'(lat), 32'd33);
        checkOutput("held start 1st result",  res,      32'd6);
        @(negedge Clk);
        checkOutput("held start idle gap", {30'd0, MD_Busy, MD_Done}, 32'd0);
        @(negedge Clk);
        MD_Start = 1'b0;
        checkOutput("held start re-accept", {31'd0, MD_Busy}, 32'd1);
        waitDone(lat, res, busyOk);
        checkOutput("held start 2nd latency", 32'(lat), 32'd33);
        checkOutput("held start 2nd result",  res,      32'd6);

        // Start together with Flush in IDLE is dropped.
        @(negedge Clk);
        MD_Op = 3'd5; MD_In_A = 32'd9; MD_In_B = 32'd0; MD_Start = 1'b1; MD_Flush = 1'b1;
        @(negedge Clk);
        MD_Start = 1'b0; MD_Flush = 1'b0;
        checkOutput("start+flush dropped", {30'd0, MD_Busy, MD_Done}, 32'd0);
        checkOutput("start+flush out held", MD_Out, 32'd6);

        // Reset mid-operation: immediate abort, no Done afterwards.
        @(negedge Clk);
        MD_Op = 3'd5; MD_In_A = 32'd100; MD_In_B = 32'd7; MD_Start = 1'b1;
        @(negedge Clk);
        MD_Start = 1'b0;
        repeat (4) @(negedge Clk);
        #2 Rst_N = 1'b0;
        #1;
        checkOutput("reset mid-op busy", {31'd0, MD_Busy}, 32'd0);
        checkOutput("reset mid-op out",  MD_Out,           32'd0);
        @(negedge Clk);
        Rst_N = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            if (MD_Done || MD_Busy) doneSeen++;
            @(negedge Clk);
        end
        checkOutput("reset mid-op no done", 32'(doneSeen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
